// File: rtl/ram_arbiter.sv
// ============================================================================
//  Module : ram_arbiter
//  Arbitrates one instruction port and one data port onto a single-ported
//  RAM: data priority, instruction anti-starvation, timeout and sticky error.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module ram_arbiter #(
  parameter int          DSTREAK_MAX = 4,
  parameter int          TIMEOUT     = 64,
  parameter logic [31:0] BADWORD     = 32'hBAD1BAD1
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        err,
  input  logic        err_clr
);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_DGRANT = 2'd1;
  localparam logic [1:0] c_IGRANT = 2'd2;

  localparam logic [1:0] c_ACCESS = 2'b10;
  localparam logic [1:0] c_ERROR  = 2'b11;

  localparam int SW = (DSTREAK_MAX < 1) ? 1 : $clog2(DSTREAK_MAX + 1);
  localparam int TW = $clog2(TIMEOUT) + 1;

  localparam logic [SW-1:0] c_STREAK_MAX = SW'(DSTREAK_MAX);
  localparam logic [TW-1:0] c_TLAST      = TW'(TIMEOUT - 1);

  logic [1:0]    state_q, state_d;
  logic [SW-1:0] dstreak_q, dstreak_d;
  logic [TW-1:0] tcount_q, tcount_d;
  logic          err_q, err_d;

  logic w_dreq;
  logic w_acc;
  logic w_fail;

  assign w_dreq = dREN | dWEN;
  assign w_acc  = (ramstate == c_ACCESS);
  // A timeout is only a failure if the RAM did not answer in that same cycle.
  assign w_fail = (ramstate == c_ERROR) | (!w_acc & (tcount_q == c_TLAST));
  assign err    = err_q;

  always_comb begin
    state_d   = state_q;
    dstreak_d = dstreak_q;
    tcount_d  = tcount_q;
    err_d     = err_q;
    iwait     = 1'b1;
    dwait     = 1'b1;
    iload     = '0;
    dload     = '0;
    ramREN    = 1'b0;
    ramWEN    = 1'b0;
    ramaddr   = '0;
    ramstore  = '0;

    if (err_clr) begin
      err_d = 1'b0;
    end

    case (state_q)
      c_IDLE: begin
        tcount_d = '0;
        if (w_dreq && !(iREN && (dstreak_q == c_STREAK_MAX))) begin
          state_d   = c_DGRANT;
          dstreak_d = iREN ? dstreak_q + SW'(1) : '0;
        end else if (iREN) begin
          state_d   = c_IGRANT;
          dstreak_d = '0;
        end
      end

      c_DGRANT: begin
        if (!w_dreq) begin
          state_d  = c_IDLE;
          tcount_d = '0;
        end else begin
          ramaddr  = daddr;
          ramWEN   = dWEN;
          ramREN   = dREN & !dWEN;
          ramstore = dstore;
          if (w_acc) begin
            dwait    = 1'b0;
            dload    = dWEN ? '0 : ramload;
            state_d  = c_IDLE;
            tcount_d = '0;
          end else if (w_fail) begin
            dwait    = 1'b0;
            dload    = BADWORD;
            err_d    = 1'b1;
            state_d  = c_IDLE;
            tcount_d = '0;
          end else begin
            tcount_d = tcount_q + TW'(1);
          end
        end
      end

      c_IGRANT: begin
        if (!iREN) begin
          state_d  = c_IDLE;
          tcount_d = '0;
        end else begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
          if (w_acc) begin
            iwait    = 1'b0;
            iload    = ramload;
            state_d  = c_IDLE;
            tcount_d = '0;
          end else if (w_fail) begin
            iwait    = 1'b0;
            iload    = BADWORD;
            err_d    = 1'b1;
            state_d  = c_IDLE;
            tcount_d = '0;
          end else begin
            tcount_d = tcount_q + TW'(1);
          end
        end
      end

      default: begin
        state_d  = c_IDLE;
        tcount_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= c_IDLE;
      dstreak_q <= '0;
      tcount_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      dstreak_q <= dstreak_d;
      tcount_q  <= tcount_d;
      err_q     <= err_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ram_arbiter.sv
// ============================================================================
//  Module : tb_ram_arbiter
//  Directed bench for ram_arbiter with a behavioural RAM and response queues.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_ram_arbiter;

  localparam logic [1:0] c_FREE   = 2'b00;
  localparam logic [1:0] c_BUSY   = 2'b01;
  localparam logic [1:0] c_ACCESS = 2'b10;
  localparam logic [1:0] c_ERROR  = 2'b11;
  localparam logic [31:0] c_BAD   = 32'hBAD1BAD1;

  logic        CLK;
  logic        nRST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic        err;
  logic        err_clr;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_d[$];
  logic [31:0] exp_i[$];

  // RAM behaviour: 0 = FREE, then ram_lat BUSY cycles, then ACCESS;
  // 1 = stuck BUSY; 2 = FREE then ERROR.
  logic [1:0] ram_mode;
  int         ram_lat;
  int         ram_cnt;

  ram_arbiter #(
    .DSTREAK_MAX(4),
    .TIMEOUT    (8),
    .BADWORD    (32'hBAD1BAD1)
  ) dut (
    .CLK     (CLK),
    .nRST    (nRST),
    .iREN    (iREN),
    .iaddr   (iaddr),
    .iwait   (iwait),
    .iload   (iload),
    .dREN    (dREN),
    .dWEN    (dWEN),
    .daddr   (daddr),
    .dstore  (dstore),
    .dwait   (dwait),
    .dload   (dload),
    .ramREN  (ramREN),
    .ramWEN  (ramWEN),
    .ramaddr (ramaddr),
    .ramstore(ramstore),
    .ramload (ramload),
    .ramstate(ramstate),
    .err     (err),
    .err_clr (err_clr)
  );

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a == 32'h40) ? 32'h12345678 : (a * 32'd3 + 32'h1000);
  endfunction

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  assign ramload = mem_fn(ramaddr);

  always_comb begin
    ramstate = c_FREE;
    if (ramREN || ramWEN) begin
      if (ram_mode == 2'd1)      ramstate = c_BUSY;
      else if (ram_cnt == 0)     ramstate = c_FREE;
      else if (ram_mode == 2'd2) ramstate = c_ERROR;
      else if (ram_cnt <= ram_lat) ramstate = c_BUSY;
      else                       ramstate = c_ACCESS;
    end
  end

  always @(posedge CLK) begin
    if (!(ramREN || ramWEN) || ramstate == c_ACCESS || ramstate == c_ERROR)
      ram_cnt <= 0;
    else
      ram_cnt <= ram_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Completions are checked against the queued expectations mid-cycle.
  always @(negedge CLK) begin
    if (nRST) begin
      if (!dwait) begin
        chk("iwait_during_d", {31'd0, iwait}, 32'd1);
        if (exp_d.size() == 0) chk("d_spurious", {31'd0, dwait}, 32'd1);
        else                   chk("dload", dload, exp_d.pop_front());
      end
      if (!iwait) begin
        chk("dwait_during_i", {31'd0, dwait}, 32'd1);
        if (exp_i.size() == 0) chk("i_spurious", {31'd0, iwait}, 32'd1);
        else                   chk("iload", iload, exp_i.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_low(input bit is_i, input string tag, output int n);
    n = 0;
    do begin
      tick();
      #3;
      n++;
    end while ((is_i ? iwait : dwait) && n < 40);
    chk({tag, "_done"}, {31'd0, (is_i ? iwait : dwait)}, 32'd0);
  endtask

  initial begin
    #100000;
    $fatal(1, "FAIL watchdog expired");
  end

  initial begin
    int n;
    int nd;
    nRST = 1'b0; iREN = 1'b0; iaddr = '0; dREN = 1'b0; dWEN = 1'b0;
    daddr = '0; dstore = '0; err_clr = 1'b0; ram_mode = 2'd0; ram_lat = 2;
    #2;
    chk("rst_iwait", {31'd0, iwait}, 32'd1);
    chk("rst_dwait", {31'd0, dwait}, 32'd1);
    chk("rst_iload", iload, 32'd0);
    chk("rst_dload", dload, 32'd0);
    chk("rst_ram", {ramREN, ramWEN, 30'd0} | ramaddr | ramstore, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    tick(); tick();
    nRST = 1'b1;

    // Data read, two BUSY cycles after the initial FREE.
    tick();
    dREN = 1'b1; daddr = 32'h40; exp_d.push_back(32'h12345678);
    wait_low(1'b0, "dread", n);
    chk("dread_latency", 32'(n), 32'd4);
    tick();
    dREN = 1'b0;
    #3 chk("dread_one_cycle", {31'd0, dwait}, 32'd1);

    // Simultaneous instruction read and data write.
    tick();
    iREN = 1'b1; iaddr = 32'h200; dREN = 1'b1; dWEN = 1'b1;
    daddr = 32'h80; dstore = 32'hCAFEF00D;
    exp_d.push_back(32'h0); exp_i.push_back(mem_fn(32'h200));
    tick(); #3;
    chk("sim_ramWEN", {31'd0, ramWEN}, 32'd1);
    chk("sim_ramREN", {31'd0, ramREN}, 32'd0);
    chk("sim_ramstore", ramstore, 32'hCAFEF00D);
    chk("sim_ramaddr", ramaddr, 32'h80);
    wait_low(1'b0, "sim_d", n);
    tick();
    dREN = 1'b0; dWEN = 1'b0;
    tick(); #3;
    chk("sim_i_ramaddr", ramaddr, 32'h200);
    chk("sim_i_ramREN", {31'd0, ramREN}, 32'd1);
    wait_low(1'b1, "sim_i", n);
    tick();
    iREN = 1'b0;

    // Starvation: data requested continuously while the instruction waits.
    ram_lat = 0;
    tick();
    iREN = 1'b1; iaddr = 32'h100; dREN = 1'b1; daddr = 32'h10;
    repeat (4) exp_d.push_back(mem_fn(32'h10));
    exp_i.push_back(mem_fn(32'h100));
    nd = 0;
    for (int c = 0; c < 60; c++) begin
      tick(); #3;
      if (!dwait) nd++;
      if (!iwait) break;
    end
    chk("starve_i_done", {31'd0, iwait}, 32'd0);
    chk("starve_d_count", 32'(nd), 32'd4);
    exp_d.push_back(mem_fn(32'h10));
    tick();
    iREN = 1'b0;
    wait_low(1'b0, "starve_d_after", n);
    tick();
    dREN = 1'b0;

    // Timeout with RAM stuck BUSY.
    ram_mode = 2'd1;
    tick();
    dREN = 1'b1; daddr = 32'h300; exp_d.push_back(c_BAD);
    wait_low(1'b0, "tmo", n);
    chk("tmo_latency", 32'(n), 32'd8);
    chk("tmo_err_before", {31'd0, err}, 32'd0);
    tick();
    dREN = 1'b0;
    #3 chk("tmo_err_set", {31'd0, err}, 32'd1);
    tick(); tick(); #3;
    chk("tmo_err_sticky", {31'd0, err}, 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    #3 chk("tmo_err_clr", {31'd0, err}, 32'd0);

    // RAM ERROR while err_clr is held: the set wins.
    ram_mode = 2'd2;
    tick();
    err_clr = 1'b1; iREN = 1'b1; iaddr = 32'h44; exp_i.push_back(c_BAD);
    wait_low(1'b1, "ramerr", n);
    chk("ramerr_latency", 32'(n), 32'd2);
    tick();
    iREN = 1'b0;
    #3 chk("ramerr_set_wins", {31'd0, err}, 32'd1);
    tick(); #3;
    chk("ramerr_cleared", {31'd0, err}, 32'd0);
    err_clr = 1'b0;

    // Abort in the second data grant cycle.
    ram_mode = 2'd0; ram_lat = 3;
    tick();
    dREN = 1'b1; daddr = 32'h50;
    tick(); #3;
    chk("abort_grant_ramREN", {31'd0, ramREN}, 32'd1);
    tick();
    dREN = 1'b0;
    #3;
    chk("abort_ramREN", {31'd0, ramREN}, 32'd0);
    chk("abort_ramaddr", ramaddr, 32'd0);
    chk("abort_dwait", {31'd0, dwait}, 32'd1);
    tick(); #3;
    chk("abort_idle_dwait", {31'd0, dwait}, 32'd1);
    chk("abort_err", {31'd0, err}, 32'd0);
    ram_lat = 2;
    tick();
    dREN = 1'b1; daddr = 32'h40; exp_d.push_back(32'h12345678);
    wait_low(1'b0, "abort_redo", n);
    chk("abort_redo_latency", 32'(n), 32'd4);
    tick();
    dREN = 1'b0;

    // Asynchronous reset during an instruction grant.
    ram_mode = 2'd1;
    tick();
    iREN = 1'b1; iaddr = 32'h60;
    tick(); tick();
    chk("rstmid_pre_ramREN", {31'd0, ramREN}, 32'd1);
    #1 nRST = 1'b0;
    #1;
    chk("rstmid_ramREN", {31'd0, ramREN}, 32'd0);
    chk("rstmid_ramaddr", ramaddr, 32'd0);
    chk("rstmid_iwait", {31'd0, iwait}, 32'd1);
    iREN = 1'b0;
    tick(); tick();
    nRST = 1'b1;
    ram_mode = 2'd0;
    tick(); #3;
    chk("rstmid_idle_ram", {31'd0, ramREN}, 32'd0);

    // After reset the streak starts at zero, so four data grants precede the fetch.
    ram_lat = 0;
    iREN = 1'b1; iaddr = 32'h104; dREN = 1'b1; daddr = 32'h14;
    repeat (4) exp_d.push_back(mem_fn(32'h14));
    exp_i.push_back(mem_fn(32'h104));
    nd = 0;
    for (int c = 0; c < 60; c++) begin
      tick(); #3;
      if (!dwait) nd++;
      if (!iwait) break;
    end
    chk("rst_streak_count", 32'(nd), 32'd4);
    tick();
    iREN = 1'b0; dREN = 1'b0;
    tick(); tick();

    chk("queue_d_empty", 32'(exp_d.size()), 32'd0);
    chk("queue_i_empty", 32'(exp_i.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
